// File: rtl/gf180mcu_fd_sc_mcu9t5v0__nandn_pkg.sv
// Shared sizing helpers for the pipelined N-input NAND macro.
// Optional scan chain build: GF180MCU_FD_SC_MCU9T5V0_NANDN_SCAN_EN.
package gf180mcu_fd_sc_mcu9t5v0__nandn_pkg;

  // Value fed into missing members of a partial AND3 group.
  localparam logic PAD_VAL = 1'b1;

  // Number of AND3 levels needed to reduce n inputs to one, never below 1.
  function automatic int unsigned clog3(input int unsigned n);
    int unsigned w;
    int unsigned lv;
    w  = n;
    lv = 0;
    while (w > 1) begin
      w  = (w + 2) / 3;
      lv = lv + 1;
    end
    return (lv == 0) ? 1 : lv;
  endfunction

  // Flops per channel produced by level k of a tree with n inputs.
  function automatic int unsigned lvl_width(input int unsigned n, input int unsigned k);
    int unsigned w;
    w = n;
    for (int unsigned i = 0; i <= k; i++) begin
      w = (w + 2) / 3;
    end
    return w;
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__nandn_level.sv
// One registered AND3 level of the NAND tree, covering all channels.
// Input width per channel is WIN; output width per channel is ceil(WIN/3).
// With GF180MCU_FD_SC_MCU9T5V0_NANDN_SCAN_EN defined, the level's flops also
// form a serial segment ordered channel 0 upward, group 0 upward.
module gf180mcu_fd_sc_mcu9t5v0__nandn_level
  import gf180mcu_fd_sc_mcu9t5v0__nandn_pkg::*;
#(
  parameter int unsigned CH    = 4,
  parameter int unsigned WIN   = 9,
  localparam int unsigned WOUT = (WIN + 2) / 3
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
`ifdef GF180MCU_FD_SC_MCU9T5V0_NANDN_SCAN_EN
  input  logic                 se_i,
  input  logic                 si_i,
  output logic                 so_o,
`endif
  input  logic [CH*WIN-1:0]    d_i,
  output logic [CH*WOUT-1:0]   q_o
);

  localparam int unsigned NFLOP = CH * WOUT;

  logic [NFLOP-1:0] grp_and;
  logic [NFLOP-1:0] q_d;
  logic [NFLOP-1:0] q_q;

  // AND each group of three inputs, padding past the channel edge.
  always_comb begin
    grp_and = '0;
    for (int unsigned c = 0; c < CH; c++) begin
      for (int unsigned j = 0; j < WOUT; j++) begin
        logic g;
        g = 1'b1;
        for (int unsigned m = 0; m < 3; m++) begin
          if ((3 * j + m) < WIN) begin
            g = g & d_i[c*WIN + 3*j + m];
          end else begin
            g = g & PAD_VAL;
          end
        end
        grp_and[c*WOUT + j] = g;
      end
    end
  end

  // Next state: scan shift overrides, otherwise advance only when enabled.
  always_comb begin
    q_d = q_q;
`ifdef GF180MCU_FD_SC_MCU9T5V0_NANDN_SCAN_EN
    if (se_i) begin
      q_d[0] = si_i;
      for (int unsigned i = 1; i < NFLOP; i++) begin
        q_d[i] = q_q[i-1];
      end
    end else
`endif
    if (en_i) begin
      q_d = grp_and;
    end
  end

  // Stage flops clear asynchronously so the inverted output reads all ones.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;
`ifdef GF180MCU_FD_SC_MCU9T5V0_NANDN_SCAN_EN
  assign so_o = q_q[NFLOP-1];
`endif

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__nandn_pipe.sv
// Pipelined multi-channel N-input NAND: a registered fan-in-3 AND tree per
// channel with an inverted final stage and a valid tag of equal latency.
// Optional scan chain build: GF180MCU_FD_SC_MCU9T5V0_NANDN_SCAN_EN.
// Timing arcs are omitted when FUNCTIONAL is defined.
module gf180mcu_fd_sc_mcu9t5v0__nandn_pipe
  import gf180mcu_fd_sc_mcu9t5v0__nandn_pkg::*;
#(
  parameter int unsigned CH  = 4,
  parameter int unsigned NIN = 9
) (
  input  logic              CLK,
  input  logic              RN,
  input  logic              E,
`ifdef GF180MCU_FD_SC_MCU9T5V0_NANDN_SCAN_EN
  input  logic              SE,
  input  logic              SI,
  output logic              SO,
`endif
  input  logic [CH*NIN-1:0] A,
  input  logic              VI,
  output logic [CH-1:0]     ZN,
  output logic              VO
);

  localparam int unsigned LEVELS = clog3(NIN);
  localparam int unsigned BW     = CH * NIN;

  // Level k reads lvl_bus[k] and writes lvl_bus[k+1], zero-extended to BW.
  logic [LEVELS:0][BW-1:0] lvl_bus;
  assign lvl_bus[0] = A;

`ifdef GF180MCU_FD_SC_MCU9T5V0_NANDN_SCAN_EN
  logic [LEVELS:0] scan_bus;
  assign scan_bus[0] = SI;
`endif

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int unsigned WIn  = (k == 0) ? NIN : lvl_width(NIN, (k == 0) ? 0 : k - 1);
    localparam int unsigned WOut = lvl_width(NIN, k);

    logic [CH*WOut-1:0] q;

    gf180mcu_fd_sc_mcu9t5v0__nandn_level #(
      .CH  (CH),
      .WIN (WIn)
    ) u_level (
      .clk_i  (CLK),
      .rst_ni (RN),
      .en_i   (E),
`ifdef GF180MCU_FD_SC_MCU9T5V0_NANDN_SCAN_EN
      .se_i   (SE),
      .si_i   (scan_bus[k]),
      .so_o   (scan_bus[k+1]),
`endif
      .d_i    (lvl_bus[k][CH*WIn-1:0]),
      .q_o    (q)
    );

    assign lvl_bus[k+1] = BW'(q);

    if (WIn < NIN) begin : g_unused
      logic unused_hi;
      assign unused_hi = ^lvl_bus[k][BW-1:CH*WIn];
    end
  end

  if (NIN > 1) begin : g_unused_last
    logic unused_last;
    assign unused_last = ^lvl_bus[LEVELS][BW-1:CH];
  end

  logic [LEVELS-1:0] vld_d;
  logic [LEVELS-1:0] vld_q;

  // Valid tag shifts in lockstep with the tree; in scan mode it closes the chain.
  always_comb begin
    vld_d = vld_q;
`ifdef GF180MCU_FD_SC_MCU9T5V0_NANDN_SCAN_EN
    if (SE) begin
      vld_d[0] = scan_bus[LEVELS];
      for (int unsigned i = 1; i < LEVELS; i++) begin
        vld_d[i] = vld_q[i-1];
      end
    end else
`endif
    if (E) begin
      vld_d[0] = VI;
      for (int unsigned i = 1; i < LEVELS; i++) begin
        vld_d[i] = vld_q[i-1];
      end
    end
  end

  // Valid flops clear with the tree so a reset discards in-flight tags.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  // Pure inverter on the last stage flops; no logic after the register.
  assign ZN = ~lvl_bus[LEVELS][CH-1:0];
  assign VO = vld_q[LEVELS-1];
`ifdef GF180MCU_FD_SC_MCU9T5V0_NANDN_SCAN_EN
  assign SO = vld_q[LEVELS-1];
`endif

`ifndef FUNCTIONAL
  // Clock-to-output arcs only; ZN is a bus, hence the full connection.
  specify
    (CLK *> ZN) = (1.0, 1.0);
    (CLK => VO) = (1.0, 1.0);
  endspecify
`endif

endmodule
